dino_game_ctrl: RTL and testbench

- Top-level sequencer for the dino runner game.
- Owns the game state machine (IDLE / RUN / OVER) and the physics tick divider.
- Scrolls one obstacle toward the dino, detects collisions against the dino height from the jump/position block, keeps the score, and drives the position block's reset and jump request.
- Sits between board buttons and the position block; its outputs feed the renderer.

---
 rtl/dino_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dino_game_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: top-level sequencer for the dino runner game.
//
// Owns the IDLE / RUN / OVER state machine and the physics tick divider.
// It scrolls one obstacle toward the dino column, checks for a collision
// against the dino height reported by the position block, keeps the score,
// and drives the position block's reset and jump request.
//
// Ports
//   clk        in   board clock
//   reset      in   synchronous, active-low reset
//   btn_start  in   start/restart button level (already synchronised)
//   btn_jump   in   jump button level
//   dino_pos   in   current dino height from the position block
//   tick       out  one-cycle physics tick pulse (RUN only)
//   jump_req   out  one-cycle jump request to the position block
//   dino_rst   out  active-high reset to the position block
//   obst_x     out  obstacle x-coordinate
//   score      out  obstacles cleared this game (saturating)
//   state      out  0 = IDLE, 1 = RUN, 2 = OVER (3 unused, recovers to IDLE)
//   game_over  out  high exactly when state == OVER
//
// Handshake: none. btn_start and btn_jump are levels; only their rising
// edges (current level 1, registered previous level 0) act. tick and
// jump_req are single-cycle strobes with no back-pressure; the position
// block must accept them in the cycle they are high.
module dino_game_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int OBST_START = 15,
  parameter int DINO_X     = 2,
  parameter int CLEAR_H    = 3,
  parameter int SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_jump,
  input  logic [3:0]         dino_pos,
  output logic               tick,
  output logic               jump_req,
  output logic               dino_rst,
  output logic [3:0]         obst_x,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]         OBST_INIT = 4'(OBST_START);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         obst_q, obst_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               tick_q, tick_d;
  logic               jump_q, jump_d;
  logic               drst_q, drst_d;
  logic               start_prev, jump_prev;

  logic start_rise;
  logic jump_rise;
  logic collision;

  assign start_rise = btn_start & ~start_prev;
  assign jump_rise  = btn_jump & ~jump_prev;

  // Compared at 32 bits so a DINO_X outside the 4-bit range never matches.
  assign collision = (32'(obst_q) == DINO_X) && (32'(dino_pos) < CLEAR_H);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    obst_d  = obst_q;
    score_d = score_q;
    tick_d  = 1'b0;
    jump_d  = 1'b0;
    drst_d  = drst_q;

    case (state_q)
      ST_IDLE: begin
        drst_d  = 1'b1;
        obst_d  = OBST_INIT;
        score_d = '0;
        div_d   = '0;
        if (start_rise) begin
          state_d = ST_RUN;
          drst_d  = 1'b0;
        end
      end

      ST_RUN: begin
        drst_d = 1'b0;
        if (collision) begin
          // Collision beats a coincident tick: everything freezes as-is.
          state_d = ST_OVER;
        end else begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
            if (obst_q == 4'd0) begin
              obst_d  = OBST_INIT;
              score_d = (score_q != SCORE_MAX) ? score_q + SCORE_W'(1) : score_q;
            end else begin
              obst_d = obst_q - 4'd1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          jump_d = jump_rise;
        end
      end

      ST_OVER: begin
        // dino_rst stays low so the dino height freezes with the game.
        drst_d = 1'b0;
        if (start_rise) begin
          state_d = ST_IDLE;
          drst_d  = 1'b1;
          obst_d  = OBST_INIT;
          score_d = '0;
          div_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        drst_d  = 1'b1;
        obst_d  = OBST_INIT;
        score_d = '0;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      obst_q     <= OBST_INIT;
      score_q    <= '0;
      tick_q     <= 1'b0;
      jump_q     <= 1'b0;
      drst_q     <= 1'b1;
      // Loading the live levels means a button held through reset release
      // does not look like a fresh press.
      start_prev <= btn_start;
      jump_prev  <= btn_jump;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      obst_q     <= obst_d;
      score_q    <= score_d;
      tick_q     <= tick_d;
      jump_q     <= jump_d;
      drst_q     <= drst_d;
      start_prev <= btn_start;
      jump_prev  <= btn_jump;
    end
  end

  assign tick      = tick_q;
  assign jump_req  = jump_q;
  assign dino_rst  = drst_q;
  assign obst_x    = obst_q;
  assign score     = score_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Testbench for dino_game_ctrl.
// dut_a: TICK_DIV=4, DINO_X=20 (never collides) for the scroll sequence.
// dut_b: TICK_DIV=4, DINO_X=2, SCORE_W=2 for vectors, corner sequences and
// randomized stimulus against a behavioural model.
module tb_dino_game_ctrl;

  localparam int B_TICK    = 4;
  localparam int B_DINO_X  = 2;
  localparam int B_CLEAR_H = 3;
  localparam int B_SMAX    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic        a_bs = 1'b0, a_bj = 1'b0;
  logic [3:0]  a_dp = 4'd0;
  logic        a_tick, a_jump, a_drst, a_go;
  logic [3:0]  a_obst;
  logic [15:0] a_score;
  logic [1:0]  a_state;

  dino_game_ctrl #(.TICK_DIV(4), .DINO_X(20)) dut_a (
    .clk(clk), .reset(reset), .btn_start(a_bs), .btn_jump(a_bj),
    .dino_pos(a_dp), .tick(a_tick), .jump_req(a_jump), .dino_rst(a_drst),
    .obst_x(a_obst), .score(a_score), .state(a_state), .game_over(a_go)
  );

  // ---------------- DUT B ----------------
  logic        b_bs = 1'b0, b_bj = 1'b0;
  logic [3:0]  b_dp = 4'd0;
  logic        b_tick, b_jump, b_drst, b_go;
  logic [3:0]  b_obst;
  logic [1:0]  b_score;
  logic [1:0]  b_state;

  dino_game_ctrl #(.TICK_DIV(B_TICK), .DINO_X(B_DINO_X), .CLEAR_H(B_CLEAR_H),
                   .SCORE_W(2)) dut_b (
    .clk(clk), .reset(reset), .btn_start(b_bs), .btn_jump(b_bj),
    .dino_pos(b_dp), .tick(b_tick), .jump_req(b_jump), .dino_rst(b_drst),
    .obst_x(b_obst), .score(b_score), .state(b_state), .game_over(b_go)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut_b ----------------
  // Game state as plain integers; the tick is derived from the number of
  // cycles spent running rather than from a divider register.
  int m_state = 0, m_obst = 15, m_score = 0, m_run = 0;
  bit m_tick = 0, m_jump = 0, m_drst = 1, m_pstart = 0, m_pjump = 0;

  task automatic model_step();
    bit sr, jr, coll;
    sr = b_bs && !m_pstart;
    jr = b_bj && !m_pjump;
    if (!reset) begin
      m_state = 0; m_tick = 0; m_jump = 0; m_drst = 1;
      m_obst = 15; m_score = 0; m_run = 0;
    end else begin
      m_tick = 0;
      m_jump = 0;
      case (m_state)
        0: begin
          m_obst = 15; m_score = 0; m_drst = 1;
          if (sr) begin m_state = 1; m_drst = 0; m_run = 0; end
        end
        1: begin
          coll = (m_obst == B_DINO_X) && (int'(b_dp) < B_CLEAR_H);
          if (coll) m_state = 2;
          else begin
            m_run++;
            if (m_run % B_TICK == 0) begin
              m_tick = 1;
              if (m_obst == 0) begin
                m_obst = 15;
                m_score = (m_score < B_SMAX) ? m_score + 1 : B_SMAX;
              end else m_obst--;
            end
            m_jump = jr;
          end
        end
        default: begin
          if (sr) begin m_state = 0; m_obst = 15; m_score = 0; m_drst = 1; end
        end
      endcase
    end
    m_pstart = b_bs;
    m_pjump  = b_bj;
  endtask

  task automatic model_check();
    n_checks++;
    if (int'(b_state) != m_state || b_tick != m_tick || b_jump != m_jump ||
        b_drst != m_drst || int'(b_obst) != m_obst || int'(b_score) != m_score ||
        b_go != (m_state == 2)) begin
      n_fail++;
      $display("FAIL model t=%0t: dut st=%0d tk=%0b jr=%0b dr=%0b ob=%0d sc=%0d go=%0b required st=%0d tk=%0b jr=%0b dr=%0b ob=%0d sc=%0d",
               $time, b_state, b_tick, b_jump, b_drst, b_obst, b_score, b_go,
               m_state, m_tick, m_jump, m_drst, m_obst, m_score);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clk_step();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic b_start_pulse();
    b_bs = 1'b1; clk_step();
    b_bs = 1'b0; clk_step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst_n; bit bs; bit bj; logic [3:0] dp;
    int st; int tk; int jr; int dr; int ob; int sc;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int cnt, found, bad, npulse;

    //            rst bs bj dp  st tk jr dr ob  sc
    vecs[0]  = '{0, 0, 0, 0,  0, 0, 0, 1, 15, 0};
    vecs[1]  = '{0, 0, 0, 0,  0, 0, 0, 1, 15, 0};
    vecs[2]  = '{0, 0, 0, 0,  0, 0, 0, 1, 15, 0};
    vecs[3]  = '{1, 0, 1, 0,  0, 0, 0, 1, 15, 0};  // jump in IDLE: ignored
    vecs[4]  = '{1, 0, 0, 0,  0, 0, 0, 1, 15, 0};
    vecs[5]  = '{1, 1, 0, 0,  1, 0, 0, 0, 15, 0};  // start rise -> RUN
    vecs[6]  = '{1, 1, 0, 0,  1, 0, 0, 0, 15, 0};  // held start: no effect
    vecs[7]  = '{1, 0, 0, 0,  1, 0, 0, 0, 15, 0};
    vecs[8]  = '{1, 0, 1, 0,  1, 0, 1, 0, 15, 0};  // jump rise
    vecs[9]  = '{1, 0, 1, 0,  1, 1, 0, 0, 14, 0};  // first tick, 4 cycles in
    vecs[10] = '{1, 0, 0, 0,  1, 0, 0, 0, 14, 0};

    for (int i = 0; i < 11; i++) begin
      reset = vecs[i].rst_n; b_bs = vecs[i].bs; b_bj = vecs[i].bj; b_dp = vecs[i].dp;
      clk_step();
      check($sformatf("vec%0d state", i), int'(b_state), vecs[i].st);
      check($sformatf("vec%0d tick", i), int'(b_tick), vecs[i].tk);
      check($sformatf("vec%0d jump_req", i), int'(b_jump), vecs[i].jr);
      check($sformatf("vec%0d dino_rst", i), int'(b_drst), vecs[i].dr);
      check($sformatf("vec%0d obst_x", i), int'(b_obst), vecs[i].ob);
      check($sformatf("vec%0d score", i), int'(b_score), vecs[i].sc);
    end
    b_bs = 0; b_bj = 0;

    // dut_a after reset: idle, no ticks for 20 cycles
    check("a reset state", int'(a_state), 0);
    check("a reset dino_rst", int'(a_drst), 1);
    check("a reset obst_x", int'(a_obst), 15);
    check("a reset score", int'(a_score), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin clk_step(); if (a_tick) cnt++; end
    check("a idle tick count", cnt, 0);

    // dut_a scroll: 17 ticks, period 4, obstacle wraps once with score 1
    a_bs = 1; clk_step(); a_bs = 0;
    check("a start state", int'(a_state), 1);
    for (int t = 1; t <= 17; t++) begin
      cnt = 0; found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
        clk_step(); cnt++;
        if (a_tick) found = 1;
      end
      check($sformatf("a tick%0d seen", t), found, 1);
      check($sformatf("a tick%0d period", t), cnt, 4);
      check($sformatf("a tick%0d obst_x", t), int'(a_obst),
            (t <= 15) ? 15 - t : (t == 16 ? 15 : 14));
      check($sformatf("a tick%0d score", t), int'(a_score), (t >= 16) ? 1 : 0);
    end

    // dut_b collision at obst_x == 2 with dino on the ground
    reset = 0; clk_step(); reset = 1;
    b_dp = 0;
    b_bs = 1; clk_step(); b_bs = 0;
    check("coll start state", int'(b_state), 1);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      clk_step();
      if (b_obst == 4'd2) found = 1;
    end
    check("coll reached x2", found, 1);
    check("coll state before edge", int'(b_state), 1);
    clk_step();
    check("coll state over", int'(b_state), 2);
    check("coll game_over", int'(b_go), 1);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      clk_step();
      if (b_obst != 4'd2 || b_score != 2'd0 || b_tick || b_state != 2'd2 || b_drst) bad++;
    end
    check("over frozen cycles bad", bad, 0);

    // restart: first rise -> IDLE (cleared), second rise -> RUN
    b_start_pulse();
    check("restart idle state", int'(b_state), 0);
    check("restart score", int'(b_score), 0);
    check("restart obst_x", int'(b_obst), 15);
    check("restart dino_rst", int'(b_drst), 1);
    b_start_pulse();
    check("restart run state", int'(b_state), 1);

    // clear: jumping high as the obstacle passes scores a point
    b_dp = 5; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      clk_step();
      if (b_score == 2'd1) found = 1;
    end
    check("clear score1", found, 1);
    check("clear still run", int'(b_state), 1);
    b_dp = 2; found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      clk_step();
      if (b_obst == 4'd2) found = 1;
    end
    check("low dino reached x2", found, 1);
    clk_step();
    check("low dino over", int'(b_state), 2);

    // held jump: exactly one pulse
    b_start_pulse(); b_start_pulse();
    b_dp = 5; b_bj = 1; npulse = 0;
    for (int k = 0; k < 10; k++) begin clk_step(); if (b_jump) npulse++; end
    b_bj = 0;
    check("held jump pulses", npulse, 1);

    // start held across reset release gives no RUN
    b_bs = 1; reset = 0; clk_step(); clk_step(); reset = 1;
    for (int k = 0; k < 5; k++) clk_step();
    check("held start thru reset", int'(b_state), 0);
    b_bs = 0; clk_step();

    // saturation: 5 wraps with SCORE_W = 2
    b_dp = 5;
    b_start_pulse();
    for (int k = 0; k < 350; k++) clk_step();
    check("sat score", int'(b_score), 3);
    check("sat state", int'(b_state), 1);

    // randomized stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 24) == 0) b_bs = ~b_bs;
      if ($urandom_range(0, 3) == 0) b_bj = ~b_bj;
      if ($urandom_range(0, 3) == 0) b_dp = 4'($urandom_range(0, 7));
      clk_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
